// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: opcodes, control-word bit positions, bus widths and memory FSM states.
// The CLEAR state exists only when MEM_CLEAR_ON_RESET_EN is defined.
package sap_pkg;

    localparam int SAP_ADDR_W = 4;
    localparam int SAP_DATA_W = 8;

    localparam logic [3:0] OP_HLT = 4'h0;
    localparam logic [3:0] OP_NOP = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_LDA = 4'h4;
    localparam logic [3:0] OP_OUT = 4'h5;
    localparam logic [3:0] OP_STA = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;

    // Control-word bit positions; names ending in _N are active-low strobes
    localparam int CW_CP    = 0;
    localparam int CW_EP    = 1;
    localparam int CW_LMA_N = 2;
    localparam int CW_LMD_N = 3;
    localparam int CW_CE_N  = 4;
    localparam int CW_LR_N  = 5;
    localparam int CW_LI_N  = 6;
    localparam int CW_EI_N  = 7;
    localparam int CW_LA_N  = 8;
    localparam int CW_EA    = 9;
    localparam int CW_SU    = 10;
    localparam int CW_EU    = 11;
    localparam int CW_LB_N  = 12;
    localparam int CW_LO_N  = 13;
    localparam int CW_HLT   = 14;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_PROG      = 2'd1,
        ST_PROG_FULL = 2'd2
`ifdef MEM_CLEAR_ON_RESET_EN
        ,
        ST_CLEAR     = 2'd3
`endif
    } mem_state_t;

endpackage

// File: rtl/sap_ram16x8.sv
// Program/data RAM: flop array with a combinational read port and one synchronous write port.
module sap_ram16x8 #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sap_memory_unit.sv
// SAP memory stage: MAR registers, 16x8 RAM and a valid/ready programming port.
// Defining MEM_CLEAR_ON_RESET_EN adds a CLEAR state that zeroes the RAM after reset.
module sap_memory_unit
    import sap_pkg::*;
#(
    parameter int ADDR_W = SAP_ADDR_W,
    parameter int DATA_W = SAP_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_addr_load_n,
    input  logic              mar_mem_load_n,
    input  logic              ram_en_n,
    input  logic              ram_load_n,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              prog_done,
    output logic              mem_busy,
    output logic [ADDR_W-1:0] mar_addr_q
);

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

`ifdef MEM_CLEAR_ON_RESET_EN
    localparam mem_state_t RESET_STATE = ST_CLEAR;
`else
    localparam mem_state_t RESET_STATE = ST_RUN;
`endif

    mem_state_t        state, state_next;
    logic [DATA_W-1:0] mar_data_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RESET_STATE;
            mar_addr_q <= '0;
            mar_data_q <= '0;
            ptr_q      <= '0;
        end else begin
            state <= state_next;
            if (state == ST_RUN) begin
                if (!mar_addr_load_n)
                    mar_addr_q <= bus_in[ADDR_W-1:0];
                if (!mar_mem_load_n)
                    mar_data_q <= bus_in;
                if (prog_mode)
                    ptr_q <= '0;
            end else if (state == ST_PROG) begin
                // Stop at the last address; PROG_FULL takes over from there
                if (prog_valid && ptr_q != PTR_MAX)
                    ptr_q <= ptr_q + 1'b1;
            end
`ifdef MEM_CLEAR_ON_RESET_EN
            else if (state == ST_CLEAR) begin
                ptr_q <= ptr_q + 1'b1;
            end
`endif
        end
    end

    // The RAM write port belongs to the CPU in RUN and to the pointer otherwise
    always_comb begin
        state_next = state;
        waddr      = mar_addr_q;
        wdata      = mar_data_q;
        we         = 1'b0;
        bus_oe     = 1'b0;
        prog_ready = 1'b0;
        prog_done  = 1'b0;
        mem_busy   = 1'b1;
        case (state)
            ST_RUN: begin
                mem_busy = 1'b0;
                bus_oe   = ~ram_en_n;
                we       = ~ram_load_n;
                if (prog_mode)
                    state_next = ST_PROG;
            end
            ST_PROG: begin
                prog_ready = 1'b1;
                waddr      = ptr_q;
                wdata      = prog_data;
                we         = prog_valid;
                if (!prog_mode)
                    state_next = ST_RUN;
                else if (prog_valid && ptr_q == PTR_MAX)
                    state_next = ST_PROG_FULL;
            end
            ST_PROG_FULL: begin
                prog_done = 1'b1;
                if (!prog_mode)
                    state_next = ST_RUN;
            end
`ifdef MEM_CLEAR_ON_RESET_EN
            ST_CLEAR: begin
                waddr = ptr_q;
                wdata = '0;
                we    = 1'b1;
                if (ptr_q == PTR_MAX)
                    state_next = ST_RUN;
            end
`endif
            default: state_next = RESET_STATE;
        endcase
    end

    sap_ram16x8 #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk   (clk),
        .raddr (mar_addr_q),
        .rdata (bus_out),
        .waddr (waddr),
        .wdata (wdata),
        .we    (we & rst_n)
    );

endmodule

// File: tb/tb_sap_memory_unit.sv
// Directed plus randomized bench for sap_memory_unit against a word-level memory model.
// Follows the DUT build: MEM_CLEAR_ON_RESET_EN enables the post-reset clear expectations.
module tb_sap_memory_unit;

    localparam int DEPTH = 16;
`ifdef MEM_CLEAR_ON_RESET_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] bus_in;
    logic       mar_addr_load_n;
    logic       mar_mem_load_n;
    logic       ram_en_n;
    logic       ram_load_n;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       prog_mode;
    logic       prog_valid;
    logic [7:0] prog_data;
    logic       prog_ready;
    logic       prog_done;
    logic       mem_busy;
    logic [3:0] mar_addr_q;

    int checks = 0;
    int errors = 0;

    // Reference model: memory words, MAR contents, programming progress, clear countdown
    logic [7:0] m_mem [DEPTH];
    bit         m_known [DEPTH];
    int         m_addr;
    logic [7:0] m_data;
    bit         m_prog;
    int         m_count;
    int         m_clear;

    sap_memory_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus_in          (bus_in),
        .mar_addr_load_n (mar_addr_load_n),
        .mar_mem_load_n  (mar_mem_load_n),
        .ram_en_n        (ram_en_n),
        .ram_load_n      (ram_load_n),
        .bus_out         (bus_out),
        .bus_oe          (bus_oe),
        .prog_mode       (prog_mode),
        .prog_valid      (prog_valid),
        .prog_data       (prog_data),
        .prog_ready      (prog_ready),
        .prog_done       (prog_done),
        .mem_busy        (mem_busy),
        .mar_addr_q      (mar_addr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_addr  = 0;
            m_data  = 8'h00;
            m_prog  = 1'b0;
            m_count = 0;
            m_clear = CLR_EN ? DEPTH : 0;
        end else if (m_clear > 0) begin
            m_mem[DEPTH - m_clear]   = 8'h00;
            m_known[DEPTH - m_clear] = 1'b1;
            m_clear--;
        end else if (!m_prog) begin
            if (!ram_load_n) begin
                m_mem[m_addr]   = m_data;
                m_known[m_addr] = 1'b1;
            end
            if (!mar_addr_load_n) m_addr = int'(bus_in) % DEPTH;
            if (!mar_mem_load_n)  m_data = bus_in;
            if (prog_mode) begin
                m_prog  = 1'b1;
                m_count = 0;
            end
        end else begin
            if (m_count < DEPTH && prog_valid) begin
                m_mem[m_count]   = prog_data;
                m_known[m_count] = 1'b1;
                m_count++;
            end
            if (!prog_mode) m_prog = 1'b0;
        end
    endtask

    // Check every output against the model, then advance one clock
    task automatic apply_stimulus();
        bit busy;
        #1;
        busy = m_prog || (m_clear > 0);
        check_output("mem_busy", mem_busy, busy);
        check_output("bus_oe", bus_oe, !busy && !ram_en_n);
        check_output("prog_ready", prog_ready, m_prog && m_count < DEPTH);
        check_output("prog_done", prog_done, m_prog && m_count == DEPTH);
        check_output("mar_addr_q", mar_addr_q, m_addr);
        if (m_known[m_addr]) check_output("bus_out", bus_out, m_mem[m_addr]);
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        mar_addr_load_n = 1'b1;
        mar_mem_load_n  = 1'b1;
        ram_en_n        = 1'b1;
        ram_load_n      = 1'b1;
        prog_valid      = 1'b0;
        bus_in          = 8'h00;
    endtask

    task automatic random_strobes();
        mar_addr_load_n = 1'($urandom_range(0, 1));
        mar_mem_load_n  = 1'($urandom_range(0, 1));
        ram_en_n        = 1'($urandom_range(0, 1));
        ram_load_n      = 1'($urandom_range(0, 1));
        bus_in          = 8'($urandom);
    endtask

    task automatic read_word(input int addr, input logic [7:0] exp, input string tag);
        set_idle();
        mar_addr_load_n = 1'b0;
        bus_in = 8'(addr);
        apply_stimulus();
        mar_addr_load_n = 1'b1;
        ram_en_n = 1'b0;
        #1;
        check_output(tag, bus_out, exp);
        apply_stimulus();
        ram_en_n = 1'b1;
    endtask

    initial begin
        logic [7:0] saved [3];
        int busy_cycles;

        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        set_idle();
        prog_mode = 1'b0;
        prog_data = 8'h00;
        rst_n = 1'b0;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        apply_stimulus();
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) apply_stimulus();

        // Program load of 0x40..0x4F, then a 17th byte that must be ignored
        prog_mode = 1'b1;
        apply_stimulus();
        prog_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            prog_data = 8'(8'h40 + i);
            apply_stimulus();
        end
        prog_data = 8'h99;
        #1;
        check_output("done_after_16", prog_done, 1'b1);
        check_output("ready_after_16", prog_ready, 1'b0);
        apply_stimulus();
        prog_valid = 1'b0;
        prog_mode = 1'b0;
        apply_stimulus();
        read_word(8'h30, 8'h40, "mem0_after_17th");

        // Fetch read at address 3
        read_word(3, 8'h43, "fetch_mem3");
        #1;
        check_output("bus_oe_released", bus_oe, 1'b0);
        apply_stimulus();

        // STA path: address 10, data 0x99
        mar_addr_load_n = 1'b0; bus_in = 8'h0A;
        apply_stimulus();
        mar_addr_load_n = 1'b1; mar_mem_load_n = 1'b0; bus_in = 8'h99;
        apply_stimulus();
        mar_mem_load_n = 1'b1; ram_load_n = 1'b0;
        apply_stimulus();
        ram_load_n = 1'b1; ram_en_n = 1'b0;
        #1;
        check_output("sta_readback", bus_out, 8'h99);
        apply_stimulus();
        ram_en_n = 1'b1;

        // Read-before-write at address 5
        mar_addr_load_n = 1'b0; bus_in = 8'h05;
        apply_stimulus();
        mar_addr_load_n = 1'b1; mar_mem_load_n = 1'b0; bus_in = 8'h11;
        apply_stimulus();
        mar_mem_load_n = 1'b1; ram_load_n = 1'b0; ram_en_n = 1'b0;
        #1;
        check_output("rbw_old_word", bus_out, 8'h45);
        apply_stimulus();
        ram_load_n = 1'b1;
        #1;
        check_output("rbw_new_word", bus_out, 8'h11);
        apply_stimulus();
        ram_en_n = 1'b1;

        // Random CPU traffic
        for (int i = 0; i < 200; i++) begin
            random_strobes();
            apply_stimulus();
        end

        // Abort after three bytes, with CPU strobes active, then re-enter with 0xAA
        set_idle();
        prog_mode = 1'b1;
        apply_stimulus();
        for (int i = 0; i < 3; i++) begin
            random_strobes();
            saved[i] = 8'($urandom);
            prog_data = saved[i];
            prog_valid = 1'b1;
            apply_stimulus();
        end
        set_idle();
        prog_mode = 1'b0;
        apply_stimulus();
        prog_mode = 1'b1;
        apply_stimulus();
        prog_valid = 1'b1; prog_data = 8'hAA;
        apply_stimulus();
        prog_valid = 1'b0; prog_mode = 1'b0;
        apply_stimulus();
        read_word(0, 8'hAA, "reentry_mem0");
        read_word(1, saved[1], "reentry_mem1");
        read_word(2, saved[2], "reentry_mem2");

        // Random mix of programming sessions and CPU traffic
        for (int i = 0; i < 300; i++) begin
            random_strobes();
            if ($urandom_range(0, 15) == 0) prog_mode = ~prog_mode;
            prog_valid = 1'($urandom_range(0, 1));
            prog_data = 8'($urandom);
            apply_stimulus();
        end

        // Reset in the middle of programming
        set_idle();
        prog_mode = 1'b0;
        apply_stimulus();
        prog_mode = 1'b1;
        apply_stimulus();
        prog_valid = 1'b1;
        prog_data = 8'h5A;
        apply_stimulus();
        apply_stimulus();
        rst_n = 1'b0;
        apply_stimulus();
        #1;
        check_output("rst_mar_addr", mar_addr_q, 4'h0);
        check_output("rst_prog_done", prog_done, 1'b0);
        check_output("rst_prog_ready", prog_ready, 1'b0);
        check_output("rst_mem_busy", mem_busy, CLR_EN);
        rst_n = 1'b1;
        prog_mode = 1'b0;
        prog_valid = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            #1;
            if (mem_busy === 1'b1) busy_cycles++;
            apply_stimulus();
        end
        check_output("busy_cycle_count", busy_cycles, CLR_EN ? DEPTH : 0);
        for (int i = 0; i < DEPTH; i++) begin
            set_idle();
            mar_addr_load_n = 1'b0;
            bus_in = 8'(i);
            apply_stimulus();
        end
        set_idle();
        apply_stimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sap_memory_unit.md
Name: sap_memory_unit

Overview:
- Memory stage directly downstream of the SAP control sequencer.
- Holds the MAR address/data registers and the 16x8 program/data RAM, and drives the shared 8-bit bus.
- Consumes the active-low strobes \L_MA, \L_MD, \CE and \L_R.
- Adds a byte-wide valid/ready programming port that loads a program into RAM while the CPU is held off.

Parameters:
ADDR_W, 4, address width; RAM depth = 2**ADDR_W
DATA_W, 8, word and bus width

Ports:
clk  in  1  clock; all state updates on posedge (sequencer changes strobes on negedge)
rst_n  in  1  reset, synchronous, active-low
bus_in  in  DATA_W  shared bus value, sampled on posedge
mar_addr_load_n  in  1  \L_MA: MAR address <= bus_in[ADDR_W-1:0]
mar_mem_load_n  in  1  \L_MD: MAR data <= bus_in
ram_en_n  in  1  \CE: drive mem[addr] onto bus
ram_load_n  in  1  \L_R: mem[addr] <= MAR data
bus_out  out  DATA_W  RAM read data
bus_oe  out  1  high when bus_out drives the bus
prog_mode  in  1  level; high requests programming
prog_valid  in  1  programming byte valid
prog_data  in  DATA_W  programming byte
prog_ready  out  1  programming byte accepted when valid & ready
prog_done  out  1  all DEPTH bytes loaded
mem_busy  out  1  unit not servicing CPU strobes
mar_addr_q  out  ADDR_W  current MAR address (debug/trace)

Behaviour:
- Reset values (rst_n low at posedge):
  - mar_addr_q=0, MAR data=0, state RUN, prog pointer=0.
  - All outputs 0 except bus_out, which follows mem[0].
  - RAM contents are not cleared, except under the optional feature.
- FSM states: RUN, PROG, PROG_FULL (plus CLEAR under the optional feature).
- RUN:
  - Strobes are honoured on posedge; they are independent, and any combination in one cycle is legal.
  - bus_out = mem[mar_addr_q], combinational read; bus_oe = ~ram_en_n.
  - Read has zero latency from the address register.
  - ram_load_n low writes MAR data into mem[mar_addr_q]. The write uses pre-edge register values.
  - \L_MA and \L_R in the same cycle: the write goes to the old address.
  - \L_MD and \L_R in the same cycle: the write uses old MAR data.
  - \CE and \L_R both low: bus shows the pre-write word (read-before-write); the write still occurs.
  - bus_in bits above ADDR_W are ignored for the address load.
- RUN -> PROG when prog_mode=1 at posedge.
  - Pointer cleared to 0.
  - CPU strobes ignored; bus_oe forced 0; mem_busy=1.
- PROG:
  - prog_ready=1 (decoded from state).
  - Each valid&ready cycle writes mem[ptr] <= prog_data, then ptr++.
  - The byte accepted at ptr=DEPTH-1 moves to PROG_FULL.
- PROG_FULL: prog_ready=0, prog_done=1; extra valid bytes are ignored.
- prog_mode falling, in PROG or PROG_FULL: next state RUN.
  - prog_done cleared; MAR registers retain their values.
  - A partially loaded program stays in RAM.
  - Re-entry restarts at address 0.
- Reset mid-programming: back to RUN (or CLEAR); pointer=0; bytes already written remain (without the feature).
- Pointer is ADDR_W bits and never wraps in PROG; PROG_FULL blocks the wrap.

Optional Feature:
- Macro MEM_CLEAR_ON_RESET_EN.
- Defined:
  - Reset enters CLEAR. After release, one word per cycle is zeroed using the pointer, addresses 0..DEPTH-1, taking DEPTH cycles.
  - Then RUN.
  - During CLEAR: mem_busy=1, bus_oe=0, prog_ready=0; CPU strobes and prog_mode are ignored until RUN.
  - Reset during CLEAR restarts at 0.
- Undefined: no CLEAR state; mem_busy=1 only in PROG/PROG_FULL.

Decomposition:
- Shared package sap_pkg holds:
  - opcode constants: HLT=0, NOP=1, ADD=2, SUB=3, LDA=4, OUT=5, STA=6, JMP=7;
  - the control-word bit indices 0..14;
  - ADDR_W/DATA_W defaults;
  - the memory FSM state enum.
- One natural sub-module, sap_ram16x8: flop array with combinational read and single synchronous write port (addr, wdata, we). The top level muxes the write port between the CPU and the programming/clear path.

Test Plan:
- Program load: prog_mode=1, send 16 bytes 0x40..0x4F with valid held high -> 16 accepts in 16 cycles, prog_done=1 after the 16th, prog_ready=0; a 17th byte is ignored and mem[0] stays 0x40.
- Fetch read: RUN, bus_in=0x03 with \L_MA low for 1 cycle, then \CE low -> bus_oe=1 and bus_out=0x43 in the same cycle; \CE high -> bus_oe=0.
- STA path: bus_in=0x0A with \L_MA, then bus_in=0x99 with \L_MD, then \L_R -> mem[10]=0x99, and a following \CE read returns 0x99.
- Same-cycle write/read: \L_R and \CE low together at addr 5 (old 0x45, MAR data 0x11) -> bus_out=0x45 that cycle, 0x11 on the next \CE read.
- Abort/re-entry: load 3 bytes, drop prog_mode, re-enter, send 0xAA -> mem[0]=0xAA, mem[1..2] keep the earlier values; CPU strobes are ignored while in PROG.
- Reset: assert rst_n=0 mid-PROG -> mar_addr_q=0, prog_done=0, state RUN. With MEM_CLEAR_ON_RESET_EN: mem_busy high for exactly 16 cycles, then all words read 0.
